// File: rtl/sensor_sequencer.sv
// sensor_sequencer: frame-level controller for the pixel array and output
// buffer. Each accepted start runs erase -> expose -> per-row conversion.
// During conversion it drives the one-hot row select and the shared ramp.
// It then waits for buf_ready before moving on to the next row.
// Optional feature macro: SENSOR_SEQ_ABORT_EN adds an abort input. When abort
// is high at an edge in any non-idle state, the sequencer returns to idle and
// clears every output.
module sensor_sequencer #(
    parameter int ROWS         = 2,
    parameter int RAMP_BITS    = 8,
    parameter int ERASE_CYCLES = 5,
    parameter int EXP_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EXP_W-1:0]     expose_time,
    input  logic                 buf_ready,
`ifdef SENSOR_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 erase,
    output logic                 expose,
    output logic [ROWS-1:0]      row_select,
    output logic                 ramp_en,
    output logic [RAMP_BITS-1:0] dramp,
    output logic                 new_row,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int PW = (EXP_W > RAMP_BITS) ? EXP_W : RAMP_BITS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [PW-1:0] ERASE_LAST = PW'(ERASE_CYCLES - 1);
    localparam logic [PW-1:0] RAMP_LAST  = PW'({RAMP_BITS{1'b1}});
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ERASE    = 3'd1,
        ST_EXPOSE   = 3'd2,
        ST_CONVERT  = 3'd3,
        ST_LATCH    = 3'd4,
        ST_WAIT_BUF = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t               state_r;
    logic [PW-1:0]        cnt_r;
    logic [RW-1:0]        cnt_row_r;
    logic [EXP_W-1:0]     exp_r;
    logic [PW-1:0]        exp_last_s;
    logic                 abort_s;

    logic                 erase_r;
    logic                 expose_r;
    logic [ROWS-1:0]      row_select_r;
    logic                 ramp_en_r;
    logic [RAMP_BITS-1:0] dramp_r;
    logic                 new_row_r;
    logic                 busy_r;
    logic                 frame_done_r;

`ifdef SENSOR_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Last exposure count value; exp_r is never 0 because 0 is latched as 1.
    assign exp_last_s = PW'(exp_r) - PW'(1);

    assign erase      = erase_r;
    assign expose     = expose_r;
    assign row_select = row_select_r;
    assign ramp_en    = ramp_en_r;
    assign dramp      = dramp_r;
    assign new_row    = new_row_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Sequencer FSM: outputs are registered to match the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            cnt_row_r    <= '0;
            exp_r        <= '0;
            erase_r      <= 1'b0;
            expose_r     <= 1'b0;
            row_select_r <= '0;
            ramp_en_r    <= 1'b0;
            dramp_r      <= '0;
            new_row_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (abort_s && (state_r != ST_IDLE)) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            cnt_row_r    <= '0;
            erase_r      <= 1'b0;
            expose_r     <= 1'b0;
            row_select_r <= '0;
            ramp_en_r    <= 1'b0;
            dramp_r      <= '0;
            new_row_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            new_row_r    <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_ERASE;
                        cnt_r     <= '0;
                        cnt_row_r <= '0;
                        exp_r     <= (expose_time == '0) ? EXP_W'(1) : expose_time;
                        erase_r   <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        erase_r      <= 1'b0;
                        expose_r     <= 1'b0;
                        row_select_r <= '0;
                        ramp_en_r    <= 1'b0;
                        dramp_r      <= '0;
                        busy_r       <= 1'b0;
                    end
                end
                ST_ERASE: begin
                    if (cnt_r == ERASE_LAST) begin
                        state_r  <= ST_EXPOSE;
                        cnt_r    <= '0;
                        erase_r  <= 1'b0;
                        expose_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + PW'(1);
                    end
                end
                ST_EXPOSE: begin
                    if (cnt_r == exp_last_s) begin
                        state_r      <= ST_CONVERT;
                        cnt_r        <= '0;
                        cnt_row_r    <= '0;
                        expose_r     <= 1'b0;
                        row_select_r <= ROWS'(1);
                        ramp_en_r    <= 1'b1;
                        dramp_r      <= '0;
                    end else begin
                        cnt_r <= cnt_r + PW'(1);
                    end
                end
                ST_CONVERT: begin
                    if (cnt_r == RAMP_LAST) begin
                        // Ramp stops at its terminal value; row stays selected.
                        state_r   <= ST_LATCH;
                        ramp_en_r <= 1'b0;
                        new_row_r <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + PW'(1);
                        dramp_r <= RAMP_BITS'(cnt_r + PW'(1));
                    end
                end
                ST_LATCH: begin
                    state_r      <= ST_WAIT_BUF;
                    row_select_r <= '0;
                    dramp_r      <= '0;
                end
                ST_WAIT_BUF: begin
                    if (buf_ready) begin
                        if (cnt_row_r == ROW_LAST) begin
                            state_r      <= ST_DONE;
                            frame_done_r <= 1'b1;
                        end else begin
                            state_r      <= ST_CONVERT;
                            cnt_r        <= '0;
                            cnt_row_r    <= cnt_row_r + RW'(1);
                            row_select_r <= ROWS'(1) << (cnt_row_r + RW'(1));
                            ramp_en_r    <= 1'b1;
                            dramp_r      <= '0;
                        end
                    end else begin
                        state_r <= ST_WAIT_BUF;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= '0;
                    cnt_row_r    <= '0;
                    erase_r      <= 1'b0;
                    expose_r     <= 1'b0;
                    row_select_r <= '0;
                    ramp_en_r    <= 1'b0;
                    dramp_r      <= '0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_sequencer.sv
// Scoreboard bench for sensor_sequencer. The stimulus queues one expected frame
// record per start. A monitor measures every busy interval and compares it
// against the queued record when the interval ends.
module tb_sensor_sequencer;

    localparam int ROWS         = 2;
    localparam int RAMP_BITS    = 8;
    localparam int ERASE_CYCLES = 5;
    localparam int EXP_W        = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [EXP_W-1:0]     expose_time;
    logic                 buf_ready;
    logic                 erase, expose, ramp_en, new_row, busy, frame_done;
    logic [ROWS-1:0]      row_select;
    logic [RAMP_BITS-1:0] dramp;
`ifdef SENSOR_SEQ_ABORT_EN
    logic                 abort;
`endif

    sensor_sequencer #(.ROWS(ROWS), .RAMP_BITS(RAMP_BITS),
                       .ERASE_CYCLES(ERASE_CYCLES), .EXP_W(EXP_W)) dut (
        .clk(clk), .reset(rst_n), .start(start), .expose_time(expose_time),
        .buf_ready(buf_ready),
`ifdef SENSOR_SEQ_ABORT_EN
        .abort(abort),
`endif
        .erase(erase), .expose(expose), .row_select(row_select),
        .ramp_en(ramp_en), .dramp(dramp), .new_row(new_row), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Expected frame record; -1 in a field means "not checked".
    typedef struct {
        int busy_len;
        int erase_len;
        int expose_len;
        int new_rows;
        int dones;
        int ramp_cycles;
        int gap;
    } frame_t;

    frame_t sb_q[$];
    int n_vec  = 0;
    int n_fail = 0;
    int idle_err = 0;

    task automatic check(string name, int act, int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_opt(string name, int act, int req);
        if (req >= 0) check(name, act, req);
    endtask

    function automatic frame_t mk(int b, int e, int x, int r, int d, int rc, int g);
        frame_t f;
        f.busy_len = b; f.erase_len = e; f.expose_len = x; f.new_rows = r;
        f.dones = d; f.ramp_cycles = rc; f.gap = g;
        return f;
    endfunction

    // Monitor: measure each busy interval and compare it at its end.
    initial begin
        bit in_frame = 1'b0;
        int blen = 0, elen = 0, xlen = 0, nrow = 0, dn = 0, rc = 0, err = 0;
        int idle_cnt = 0, gap = 0, prev_dramp = 0, last_fd = 0;
        bit prev_ramp = 1'b0;
        int exp_rs;
        frame_t f;
        forever begin
            @(negedge clk);
            if (busy) begin
                if (!in_frame) begin
                    in_frame = 1'b1; gap = idle_cnt;
                    blen = 0; elen = 0; xlen = 0; nrow = 0; dn = 0; rc = 0; err = 0;
                    prev_ramp = 1'b0; prev_dramp = 0;
                end
                blen++;
                elen += int'(erase);
                xlen += int'(expose);
                dn   += int'(frame_done);
                last_fd = int'(frame_done);
                exp_rs = (nrow < ROWS) ? (1 << nrow) : 0;
                if (erase && expose) err++;
                if (ramp_en) begin
                    rc++;
                    if (new_row) err++;
                    if (prev_ramp ? (int'(dramp) != prev_dramp + 1) : (dramp != '0)) err++;
                    if (int'(row_select) != exp_rs) err++;
                end else if (new_row) begin
                    if (int'(dramp) != 255 || int'(row_select) != exp_rs || !prev_ramp) err++;
                    nrow++;
                end else begin
                    if (row_select != '0 || dramp != '0) err++;
                end
                prev_ramp = ramp_en;
                prev_dramp = int'(dramp);
            end else begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    idle_cnt = 0;
                    if (sb_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        f = sb_q.pop_front();
                        check_opt("busy_len", blen, f.busy_len);
                        check_opt("erase_len", elen, f.erase_len);
                        check_opt("expose_len", xlen, f.expose_len);
                        check_opt("new_row_count", nrow, f.new_rows);
                        check_opt("frame_done_count", dn, f.dones);
                        check_opt("ramp_cycles", rc, f.ramp_cycles);
                        check_opt("idle_gap", gap, f.gap);
                        check("frame_waveform_errors", err, 0);
                        if (f.dones == 1) check("frame_done_last_cycle", last_fd, 1);
                    end
                end
                idle_cnt++;
                if (erase || expose || row_select != '0 || ramp_en || dramp != '0 ||
                    new_row || frame_done) idle_err++;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int t = 0;
        while ((sb_q.size() != 0 || busy) && t < budget) begin
            @(negedge clk); t++;
        end
        check("wait_idle_timeout", int'(t >= budget), 0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_erase"}, int'(erase), 0);
        check({tag, "_expose"}, int'(expose), 0);
        check({tag, "_row_select"}, int'(row_select), 0);
        check({tag, "_ramp_en"}, int'(ramp_en), 0);
        check({tag, "_dramp"}, int'(dramp), 0);
        check({tag, "_new_row"}, int'(new_row), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    // Directed stimulus.
    initial begin
        int t;
        int fd_seen;
        rst_n = 1'b0; start = 1'b0; expose_time = 16'd10; buf_ready = 1'b1;
`ifdef SENSOR_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal frame, with start pulses while busy that must be ignored.
        sb_q.push_back(mk(532, 5, 10, 2, 1, 512, -1));
        pulse_start();
        repeat (50) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (300) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_idle(2000);
        repeat (10) @(negedge clk);
        check("no_queued_frame_busy", int'(busy), 0);

        // Backpressure: buf_ready low for 20 edges inside WAIT_BUF.
        sb_q.push_back(mk(552, 5, 10, 2, 1, 512, -1));
        pulse_start();
        t = 0;
        while (!new_row && t < 1000) begin @(negedge clk); t++; end
        check("new_row_timeout", int'(t >= 1000), 0);
        buf_ready = 1'b0;
        repeat (21) @(posedge clk);
        @(negedge clk);
        check("waitbuf_hold_ramp_en", int'(ramp_en), 0);
        check("waitbuf_hold_row_select", int'(row_select), 0);
        buf_ready = 1'b1;
        @(negedge clk);
        check("row1_start_ramp_en", int'(ramp_en), 1);
        check("row1_start_row_select", int'(row_select), 2);
        check("row1_start_dramp", int'(dramp), 0);
        wait_idle(2000);

        // expose_time=0 acts as 1; a mid-frame change only affects the next frame.
        expose_time = 16'd0;
        sb_q.push_back(mk(523, 5, 1, 2, 1, 512, -1));
        pulse_start();
        repeat (20) @(negedge clk);
        expose_time = 16'd3;
        wait_idle(2000);
        sb_q.push_back(mk(525, 5, 3, 2, 1, 512, -1));
        pulse_start();
        wait_idle(2000);

        // start held high: back-to-back frames separated by one idle cycle.
        sb_q.push_back(mk(525, 5, 3, 2, 1, 512, -1));
        sb_q.push_back(mk(525, 5, 3, 2, 1, 512, 1));
        sb_q.push_back(mk(525, 5, 3, 2, 1, 512, 1));
        @(negedge clk); start = 1'b1;
        fd_seen = 0; t = 0;
        while (fd_seen < 3 && t < 3000) begin
            @(negedge clk); t++;
            if (frame_done) fd_seen++;
        end
        start = 1'b0;
        check("b2b_timeout", int'(t >= 3000), 0);
        wait_idle(2000);

        // Asynchronous reset at dramp=100 of row 0.
        sb_q.push_back(mk(-1, 5, 3, 0, 0, -1, -1));
        pulse_start();
        t = 0;
        while (!(ramp_en && dramp == 8'd100) && t < 1000) begin @(negedge clk); t++; end
        check("dramp100_timeout", int'(t >= 1000), 0);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(mk(525, 5, 3, 2, 1, 512, -1));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("restart_erase", int'(erase), 1);
        wait_idle(2000);

`ifdef SENSOR_SEQ_ABORT_EN
        // Abort during EXPOSE: idle next cycle, no frame_done.
        sb_q.push_back(mk(-1, 5, -1, 0, 0, 0, -1));
        pulse_start();
        t = 0;
        while (!expose && t < 100) begin @(negedge clk); t++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_all_zero("abort");
        wait_idle(100);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        check("idle_quiet_errors", idle_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_sequencer.md
Name: sensor_sequencer

Overview:
Frame-level controller for the pixel array and output buffer. It runs one erase → expose → row-by-row conversion sequence per start request. During conversion it drives the one-hot row select and the shared analog/digital ramp, and it pulses new_row so the output buffer captures each row. Before advancing to the next row it waits for the buffer to signal that it has drained, which gives backpressure from the readout side.

Parameters:
ROWS, 2, number of pixel rows (width of row_select)
RAMP_BITS, 8, digital ramp width; one conversion lasts 2^RAMP_BITS cycles
ERASE_CYCLES, 5, cycles erase is held high; must be >=1
EXP_W, 16, width of expose_time

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  frame request; sampled only in IDLE
expose_time  in  EXP_W  exposure length in cycles; latched on accepted start
buf_ready  in  1  output buffer has drained the previous row and can accept the next
erase  out  1  pixel erase
expose  out  1  pixel expose
row_select  out  ROWS  one-hot row read enable
ramp_en  out  1  analog ramp run
dramp  out  RAMP_BITS  digital ramp / counter value
new_row  out  1  one-cycle pulse that tells the buffer to capture the current row
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at the end of the frame

Behaviour:
- All outputs are registered. On reset low: state=IDLE and all outputs 0, asynchronously. This also applies when reset falls mid-frame; no frame_done is issued.
- States: IDLE, ERASE, EXPOSE, CONVERT, LATCH, WAIT_BUF, DONE. A single phase counter (width max(EXP_W, RAMP_BITS)) plus a row index cnt_row (clog2(ROWS) bits).
- IDLE: when start=1 at an edge, latch expose_time (a value of 0 is treated as 1). Go to ERASE; erase is high from the next cycle.
- ERASE: erase=1 for exactly ERASE_CYCLES cycles, then go to EXPOSE.
- EXPOSE: expose=1 for exactly the latched exposure count, then go to CONVERT with row=0. erase and expose are never high together.
- CONVERT: row_select=1<<row and ramp_en=1. dramp starts at 0 and increments by 1 per cycle up to 2^RAMP_BITS-1 (256 cycles at default), with no wrap. After the terminal value, go to LATCH.
- LATCH: one cycle. new_row=1, row_select still asserted, dramp holds its terminal value, ramp_en=0. Then go to WAIT_BUF.
- WAIT_BUF: row_select=0 and dramp=0. Stay at least 1 cycle, and exit on the first edge with buf_ready=1.
  - If row==ROWS-1, go to DONE.
  - Otherwise row+1 and go to CONVERT.
  - buf_ready has no effect in any other state.
- DONE: frame_done=1 for one cycle, busy still 1, then go to IDLE. A start held high is accepted in the following IDLE cycle, so consecutive frames are separated by exactly 1 IDLE cycle.
- start asserted while busy is ignored and not queued. A change to expose_time mid-frame has no effect on the current frame.
- Frame length with buf_ready held high = ERASE_CYCLES + T + ROWS*(2^RAMP_BITS + 2) + 1 cycles of busy.

Optional Feature:
SENSOR_SEQ_ABORT_EN:
- When defined: adds input port abort (1 bit). abort=1 at an edge in any non-IDLE state forces IDLE on the next cycle with all outputs 0 and no frame_done pulse. abort has priority over every other transition; it is ignored in IDLE.
- When undefined: the port is absent and a frame can only be stopped by reset.

Test Plan:
- Defaults, expose_time=10, buf_ready=1, one start pulse → erase high 5 cycles, then expose high 10 cycles; busy high exactly 532 cycles; a single frame_done in the last busy cycle; new_row pulses exactly 2 times.
- During CONVERT → dramp sequence 0..255, contiguous, no skips; row_select=01 for row 0 and 10 for row 1; row_select==0 outside CONVERT/LATCH; new_row coincides with dramp=255.
- buf_ready held 0 for 20 cycles after the first new_row → WAIT_BUF held for 20 cycles with outputs quiescent; row-1 CONVERT starts 1 cycle after buf_ready rises; busy extends to 552 cycles.
- expose_time=0 → expose high exactly 1 cycle. Set expose_time=3 mid-frame, then restart → the current frame is unchanged and the next frame's expose lasts 3 cycles.
- start held high continuously → back-to-back frames separated by exactly 1 IDLE cycle (busy=0); start pulses while busy produce no extra frames.
- reset driven low at dramp=100 → all outputs 0 immediately (asynchronous), no frame_done; after release, start begins a clean frame with erase. With SENSOR_SEQ_ABORT_EN: abort during EXPOSE → IDLE next cycle, no frame_done.
